count_multi: RTL and testbench

- Parametrised multi-channel up/down counter; next generation of the single-channel up/down count block.
- Adds per-channel load, a shared programmable step, a configurable terminal value, wrap or saturate mode, and overflow/underflow reporting.
- Used as a timing/benchmark datapath block and as a generic event-counter bank in the training designs.

---
 rtl/count_multi_pkg.sv | 16 +
 rtl/count_multi_if.sv | 31 +++
 rtl/count_multi_channel.sv | 103 ++++++++++
 rtl/count_multi.sv | 55 +++++
 tb/tb_count_multi.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_multi_pkg.sv
// Shared types and helpers for the count_multi counter bank.
package count_multi_pkg;

  // Overflow behaviour of a channel: wrap modulo MAX_VAL+1 or clamp at the limits.
  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } count_mode_t;

  // Limit a requested step to the counter range so one step never exceeds MAX_VAL.
  function automatic int unsigned clamp_step(input int unsigned step,
                                             input int unsigned max_val);
    return (step > max_val) ? max_val : step;
  endfunction

endpackage

// File: rtl/count_multi_if.sv
// Request/result bundle of the count_multi counter bank.
// Requests (up/down/load/step/clr_flags) are level signals sampled on every
// rising clk edge; there is no handshake and no backpressure, every request
// present at an edge is acted on at that edge.
interface count_multi_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int WIDTH        = 16,
  parameter int STEP_WIDTH   = 4
);
  logic [NUM_CHANNELS-1:0]            up;
  logic [NUM_CHANNELS-1:0]            down;
  logic [NUM_CHANNELS-1:0]            load;
  logic [NUM_CHANNELS-1:0][WIDTH-1:0] load_val;
  logic [STEP_WIDTH-1:0]              step;
  logic                               clr_flags;
  logic [NUM_CHANNELS-1:0][WIDTH-1:0] out;
  logic [NUM_CHANNELS-1:0]            overflow;
  logic [NUM_CHANNELS-1:0]            underflow;
  logic [NUM_CHANNELS-1:0]            at_max;
  logic [NUM_CHANNELS-1:0]            at_min;

  modport master (
    output up, down, load, load_val, step, clr_flags,
    input  out, overflow, underflow, at_max, at_min
  );

  modport slave (
    input  up, down, load, load_val, step, clr_flags,
    output out, overflow, underflow, at_max, at_min
  );
endinterface

// File: rtl/count_multi_channel.sv
// One up/down counter of the bank with its overflow/underflow flags.
// Optional build macro COUNT_MULTI_STICKY_FLAGS_EN: flags latch until clr_flags.
module count_multi_channel
  import count_multi_pkg::*;
#(
  parameter int          WIDTH    = 16,
  parameter int unsigned MAX_VAL  = 2**WIDTH-1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] es,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             underflow,
  output logic             at_max,
  output logic             at_min
);

  localparam int          W1      = WIDTH + 1;
  localparam logic [WIDTH:0] MAX_EXT = W1'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + 1'b1;
  localparam count_mode_t MODE    = SATURATE ? MODE_SATURATE : MODE_WRAP;

  logic [WIDTH-1:0] out_q, out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             ovf_event, unf_event;
  logic [WIDTH:0]   out_ext, es_ext, ld_ext;
  logic [WIDTH:0]   sum_ext, wrap_up_ext, wrap_dn_ext;

  // Next count and this edge's overflow/underflow events, at WIDTH+1 bits.
  always_comb begin
    out_ext     = {1'b0, out_q};
    es_ext      = {1'b0, es};
    ld_ext      = {1'b0, load_val};
    sum_ext     = out_ext + es_ext;
    wrap_up_ext = sum_ext - MOD_EXT;
    wrap_dn_ext = out_ext + MOD_EXT - es_ext;
    out_d       = out_q;
    ovf_event   = 1'b0;
    unf_event   = 1'b0;
    if (load) begin
      out_d = (ld_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
    end else if (up && !down) begin
      if (sum_ext <= MAX_EXT) begin
        out_d = sum_ext[WIDTH-1:0];
      end else begin
        ovf_event = 1'b1;
        out_d     = (MODE == MODE_SATURATE) ? MAX_EXT[WIDTH-1:0] : wrap_up_ext[WIDTH-1:0];
      end
    end else if (down && !up) begin
      if (out_ext >= es_ext) begin
        out_d = out_q - es;
      end else begin
        unf_event = 1'b1;
        out_d     = (MODE == MODE_SATURATE) ? '0 : wrap_dn_ext[WIDTH-1:0];
      end
    end
  end

`ifdef COUNT_MULTI_STICKY_FLAGS_EN
  // Flags hold until cleared; a new event on the clearing edge keeps the flag set.
  always_comb begin
    overflow_d  = ovf_event | (overflow_q  & ~clr_flags);
    underflow_d = unf_event | (underflow_q & ~clr_flags);
  end
`else
  logic unused_clr_flags;
  assign unused_clr_flags = clr_flags;

  // Flags are one-cycle pulses registered alongside the count.
  always_comb begin
    overflow_d  = ovf_event;
    underflow_d = unf_event;
  end
`endif

  // Count and flag registers; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out       = out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign at_max    = (out_q == MAX_EXT[WIDTH-1:0]);
  assign at_min    = (out_q == '0);

endmodule

// File: rtl/count_multi.sv
// Multi-channel up/down counter bank: clamps the shared step once and fans
// it and the flag clear out to NUM_CHANNELS independent counters.
// Optional build macro COUNT_MULTI_STICKY_FLAGS_EN (see count_multi_channel).
module count_multi
  import count_multi_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter int          WIDTH        = 16,
  parameter int          STEP_WIDTH   = 4,
  parameter int unsigned MAX_VAL      = 2**WIDTH-1,
  parameter bit          SATURATE     = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  count_multi_if.slave  bus
);

  logic [WIDTH-1:0]                   es;
  logic [NUM_CHANNELS-1:0][WIDTH-1:0] out_w;
  logic [NUM_CHANNELS-1:0]            overflow_w, underflow_w, at_max_w, at_min_w;

  // Effective step shared by all channels: min(step, MAX_VAL).
  always_comb begin
    es = WIDTH'(clamp_step(32'(bus.step), MAX_VAL));
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    count_multi_channel #(
      .WIDTH    (WIDTH),
      .MAX_VAL  (MAX_VAL),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .up        (bus.up[i]),
      .down      (bus.down[i]),
      .load      (bus.load[i]),
      .load_val  (bus.load_val[i]),
      .es        (es),
      .clr_flags (bus.clr_flags),
      .out       (out_w[i]),
      .overflow  (overflow_w[i]),
      .underflow (underflow_w[i]),
      .at_max    (at_max_w[i]),
      .at_min    (at_min_w[i])
    );
  end

  assign bus.out       = out_w;
  assign bus.overflow  = overflow_w;
  assign bus.underflow = underflow_w;
  assign bus.at_max    = at_max_w;
  assign bus.at_min    = at_min_w;

endmodule

// File: tb/tb_count_multi.sv
// Bench for count_multi: a wrap and a saturate instance, both WIDTH=4, MAX_VAL=9.
module tb_count_multi;

  localparam int NCH  = 4;
  localparam int W    = 4;
  localparam int SW   = 4;
  localparam int MAXV = 9;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  count_multi_if #(.NUM_CHANNELS(NCH), .WIDTH(W), .STEP_WIDTH(SW)) if_w ();
  count_multi_if #(.NUM_CHANNELS(NCH), .WIDTH(W), .STEP_WIDTH(SW)) if_s ();

  count_multi #(.NUM_CHANNELS(NCH), .WIDTH(W), .STEP_WIDTH(SW), .MAX_VAL(MAXV), .SATURATE(1'b0))
    dut_w (.clk(clk), .rst(rst), .bus(if_w));
  count_multi #(.NUM_CHANNELS(NCH), .WIDTH(W), .STEP_WIDTH(SW), .MAX_VAL(MAXV), .SATURATE(1'b1))
    dut_s (.clk(clk), .rst(rst), .bus(if_s));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_w.up = '0; if_w.down = '0; if_w.load = '0; if_w.load_val = '0;
    if_w.step = '0; if_w.clr_flags = 1'b0;
    if_s.up = '0; if_s.down = '0; if_s.load = '0; if_s.load_val = '0;
    if_s.step = '0; if_s.clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #22;
    if (if_w.out !== '0) begin n_fail++; $display("FAIL reset_out_w: got %h expected 0", if_w.out); end
    n_checks++;
    if (if_s.out !== '0) begin n_fail++; $display("FAIL reset_out_s: got %h expected 0", if_s.out); end
    n_checks++;
    if (if_w.at_min !== 4'hf) begin n_fail++; $display("FAIL reset_at_min: got %b expected 1111", if_w.at_min); end
    n_checks++;
    if (if_w.at_max !== 4'h0) begin n_fail++; $display("FAIL reset_at_max: got %b expected 0000", if_w.at_max); end
    n_checks++;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) tick();
    if (if_w.out !== '0 || if_s.out !== '0) begin
      n_fail++; $display("FAIL idle_out: got %h/%h expected 0/0", if_w.out, if_s.out);
    end
    n_checks++;
    if (if_w.at_min !== 4'hf || if_s.at_min !== 4'hf) begin
      n_fail++; $display("FAIL idle_at_min: got %b/%b expected 1111", if_w.at_min, if_s.at_min);
    end
    n_checks++;
    if ((if_w.overflow | if_w.underflow | if_s.overflow | if_s.underflow) !== 4'h0) begin
      n_fail++; $display("FAIL idle_flags: got %b%b%b%b expected all 0",
                         if_w.overflow, if_w.underflow, if_s.overflow, if_s.underflow);
    end
    n_checks++;
  endtask

  task automatic test_wrap();
    clear_inputs();
    if_w.load[0] = 1'b1; if_w.load_val[0] = 4'd8;
    tick();
    if (if_w.out[0] !== 4'd8) begin n_fail++; $display("FAIL wrap_load: got %0d expected 8", if_w.out[0]); end
    n_checks++;
    if_w.load[0] = 1'b0; if_w.up[0] = 1'b1; if_w.step = 4'd3;
    tick();
    if (if_w.out[0] !== 4'd1) begin n_fail++; $display("FAIL wrap_up_out: got %0d expected 1", if_w.out[0]); end
    n_checks++;
    if (if_w.overflow !== 4'b0001) begin n_fail++; $display("FAIL wrap_up_ovf: got %b expected 0001", if_w.overflow); end
    n_checks++;
    if_w.up[0] = 1'b0;
    tick();
    if (if_w.overflow[0] !== 1'b0 || if_w.out[0] !== 4'd1) begin
      n_fail++; $display("FAIL wrap_ovf_pulse: got ovf=%b out=%0d expected ovf=0 out=1", if_w.overflow[0], if_w.out[0]);
    end
    n_checks++;
    if_w.down[0] = 1'b1; if_w.step = 4'd2;
    tick();
    if (if_w.out[0] !== 4'd9) begin n_fail++; $display("FAIL wrap_dn_out: got %0d expected 9", if_w.out[0]); end
    n_checks++;
    if (if_w.underflow !== 4'b0001 || if_w.at_max[0] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_dn_unf: got unf=%b at_max=%b expected 0001/1", if_w.underflow, if_w.at_max[0]);
    end
    n_checks++;
    if_w.down[0] = 1'b0;
    tick();
    if (if_w.underflow[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_unf_pulse: got %b expected 0", if_w.underflow[0]); end
    n_checks++;
    if (if_w.out[1] !== 4'd0) begin n_fail++; $display("FAIL wrap_ch1_idle: got %0d expected 0", if_w.out[1]); end
    n_checks++;
  endtask

  task automatic test_saturate();
    clear_inputs();
    if_s.load[0] = 1'b1; if_s.load_val[0] = 4'd8;
    tick();
    if_s.load[0] = 1'b0; if_s.up[0] = 1'b1; if_s.step = 4'd3;
    tick();
    if (if_s.out[0] !== 4'd9 || if_s.overflow[0] !== 1'b1) begin
      n_fail++; $display("FAIL sat_up: got out=%0d ovf=%b expected 9/1", if_s.out[0], if_s.overflow[0]);
    end
    n_checks++;
    tick();
    if (if_s.out[0] !== 4'd9 || if_s.overflow[0] !== 1'b1) begin
      n_fail++; $display("FAIL sat_up_at_max: got out=%0d ovf=%b expected 9/1", if_s.out[0], if_s.overflow[0]);
    end
    n_checks++;
    if_s.up[0] = 1'b0; if_s.load[0] = 1'b1; if_s.load_val[0] = 4'd1;
    tick();
    if (if_s.out[0] !== 4'd1 || if_s.overflow[0] !== 1'b0) begin
      n_fail++; $display("FAIL sat_load: got out=%0d ovf=%b expected 1/0", if_s.out[0], if_s.overflow[0]);
    end
    n_checks++;
    if_s.load[0] = 1'b0; if_s.down[0] = 1'b1; if_s.step = 4'd5;
    tick();
    if (if_s.out[0] !== 4'd0 || if_s.underflow[0] !== 1'b1) begin
      n_fail++; $display("FAIL sat_dn: got out=%0d unf=%b expected 0/1", if_s.out[0], if_s.underflow[0]);
    end
    n_checks++;
    tick();
    if (if_s.out[0] !== 4'd0 || if_s.underflow[0] !== 1'b1) begin
      n_fail++; $display("FAIL sat_dn_at_min: got out=%0d unf=%b expected 0/1", if_s.out[0], if_s.underflow[0]);
    end
    n_checks++;
    clear_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    clear_inputs();
    if_w.load[1] = 1'b1; if_w.load_val[1] = 4'd5;
    tick();
    if_w.load[1] = 1'b0; if_w.up[1] = 1'b1; if_w.down[1] = 1'b1; if_w.step = 4'd3;
    tick();
    if (if_w.out[1] !== 4'd5 || if_w.overflow[1] !== 1'b0 || if_w.underflow[1] !== 1'b0) begin
      n_fail++; $display("FAIL updown_hold: got out=%0d ovf=%b unf=%b expected 5/0/0",
                         if_w.out[1], if_w.overflow[1], if_w.underflow[1]);
    end
    n_checks++;
    if_w.down[1] = 1'b0; if_w.load[1] = 1'b1; if_w.load_val[1] = 4'd7;
    tick();
    if (if_w.out[1] !== 4'd7) begin n_fail++; $display("FAIL load_over_up: got %0d expected 7", if_w.out[1]); end
    n_checks++;
    if_w.load_val[1] = 4'd15;
    tick();
    if (if_w.out[1] !== 4'd9 || if_w.at_max[1] !== 1'b1) begin
      n_fail++; $display("FAIL load_clamp: got out=%0d at_max=%b expected 9/1", if_w.out[1], if_w.at_max[1]);
    end
    n_checks++;
    if_w.load[1] = 1'b0; if_w.step = 4'd0;
    tick();
    if (if_w.out[1] !== 4'd9 || if_w.overflow[1] !== 1'b0) begin
      n_fail++; $display("FAIL step0_hold: got out=%0d ovf=%b expected 9/0", if_w.out[1], if_w.overflow[1]);
    end
    n_checks++;
    if_w.up[1] = 1'b0; if_w.load[1] = 1'b1; if_w.load_val[1] = 4'd2;
    tick();
    // step 15 is clamped to 9: 2+9=11 wraps to 1
    if_w.load[1] = 1'b0; if_w.up[1] = 1'b1; if_w.step = 4'd15;
    tick();
    if (if_w.out[1] !== 4'd1 || if_w.overflow[1] !== 1'b1) begin
      n_fail++; $display("FAIL step_clamp: got out=%0d ovf=%b expected 1/1", if_w.out[1], if_w.overflow[1]);
    end
    n_checks++;
    clear_inputs();
    tick();
  endtask

  task automatic test_flags();
    clear_inputs();
    if_w.load[2] = 1'b1; if_w.load_val[2] = 4'd5;
    tick();
    if_w.load[2] = 1'b0; if_w.up[2] = 1'b1; if_w.step = 4'd6;
    tick();
    if (if_w.overflow[2] !== 1'b1 || if_w.out[2] !== 4'd1) begin
      n_fail++; $display("FAIL flag_ovf: got ovf=%b out=%0d expected 1/1", if_w.overflow[2], if_w.out[2]);
    end
    n_checks++;
    if_w.up[2] = 1'b0;
`ifdef COUNT_MULTI_STICKY_FLAGS_EN
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_w.overflow[2] !== 1'b1) begin
        n_fail++; $display("FAIL sticky_hold_%0d: got %b expected 1", i, if_w.overflow[2]);
      end
      n_checks++;
    end
`else
    tick();
    if (if_w.overflow[2] !== 1'b0) begin n_fail++; $display("FAIL pulse_end: got %b expected 0", if_w.overflow[2]); end
    n_checks++;
`endif
    // clear on the same edge as a new overflow (1+9=10 -> 0): flag set
    if_w.clr_flags = 1'b1; if_w.up[2] = 1'b1; if_w.step = 4'd9;
    tick();
    if (if_w.overflow[2] !== 1'b1 || if_w.out[2] !== 4'd0) begin
      n_fail++; $display("FAIL clr_with_event: got ovf=%b out=%0d expected 1/0", if_w.overflow[2], if_w.out[2]);
    end
    n_checks++;
    if_w.up[2] = 1'b0;
    tick();
    if (if_w.overflow[2] !== 1'b0 || if_w.out[2] !== 4'd0) begin
      n_fail++; $display("FAIL clr_alone: got ovf=%b out=%0d expected 0/0", if_w.overflow[2], if_w.out[2]);
    end
    n_checks++;
    clear_inputs();
    tick();
  endtask

  // reference model for one channel
  function automatic void model_step(input int cur, input bit u, input bit d, input bit l,
                                     input int lv, input int st, input bit sat,
                                     output int nxt, output bit ov, output bit un);
    int es;
    es  = (st > MAXV) ? MAXV : st;
    nxt = cur; ov = 1'b0; un = 1'b0;
    if (l) begin
      nxt = (lv > MAXV) ? MAXV : lv;
    end else if (u && !d) begin
      if (cur + es > MAXV) begin
        ov  = 1'b1;
        nxt = sat ? MAXV : cur + es - (MAXV + 1);
      end else nxt = cur + es;
    end else if (d && !u) begin
      if (cur < es) begin
        un  = 1'b1;
        nxt = sat ? 0 : cur + (MAXV + 1) - es;
      end else nxt = cur - es;
    end
  endfunction

  task automatic test_soak();
    int m_w[NCH], m_s[NCH];
    bit fo_w[NCH], fu_w[NCH], fo_s[NCH], fu_s[NCH];
    logic [NCH-1:0][W-1:0] e_out_w, e_out_s;
    logic [NCH-1:0] e_ov_w, e_un_w, e_ov_s, e_un_s, e_max_w, e_min_w;
    int nx; bit ov, un;
    for (int c = 0; c < NCH; c++) begin
      m_w[c] = if_w.out[c]; m_s[c] = if_s.out[c];
      fo_w[c] = if_w.overflow[c]; fu_w[c] = if_w.underflow[c];
      fo_s[c] = if_s.overflow[c]; fu_s[c] = if_s.underflow[c];
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        #2 rst = 1'b1;
        #1;
        if (if_w.out !== '0 || if_s.out !== '0 || (if_w.overflow | if_s.underflow) !== '0) begin
          n_fail++; $display("FAIL async_reset: got %h/%h expected 0/0", if_w.out, if_s.out);
        end
        n_checks++;
        #1 rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          m_w[c] = 0; m_s[c] = 0; fo_w[c] = 0; fu_w[c] = 0; fo_s[c] = 0; fu_s[c] = 0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if_w.up[c] = 1'($urandom_range(0, 1)); if_w.down[c] = 1'($urandom_range(0, 1));
        if_w.load[c] = ($urandom_range(0, 9) == 0); if_w.load_val[c] = 4'($urandom_range(0, 15));
        if_s.up[c] = 1'($urandom_range(0, 1)); if_s.down[c] = 1'($urandom_range(0, 1));
        if_s.load[c] = ($urandom_range(0, 9) == 0); if_s.load_val[c] = 4'($urandom_range(0, 15));
      end
      if_w.step = 4'($urandom_range(0, 15)); if_s.step = 4'($urandom_range(0, 15));
      if_w.clr_flags = ($urandom_range(0, 7) == 0); if_s.clr_flags = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < NCH; c++) begin
        model_step(m_w[c], if_w.up[c], if_w.down[c], if_w.load[c], int'(if_w.load_val[c]),
                   int'(if_w.step), 1'b0, nx, ov, un);
        m_w[c] = nx;
`ifdef COUNT_MULTI_STICKY_FLAGS_EN
        fo_w[c] = ov | (fo_w[c] & !if_w.clr_flags); fu_w[c] = un | (fu_w[c] & !if_w.clr_flags);
`else
        fo_w[c] = ov; fu_w[c] = un;
`endif
        model_step(m_s[c], if_s.up[c], if_s.down[c], if_s.load[c], int'(if_s.load_val[c]),
                   int'(if_s.step), 1'b1, nx, ov, un);
        m_s[c] = nx;
`ifdef COUNT_MULTI_STICKY_FLAGS_EN
        fo_s[c] = ov | (fo_s[c] & !if_s.clr_flags); fu_s[c] = un | (fu_s[c] & !if_s.clr_flags);
`else
        fo_s[c] = ov; fu_s[c] = un;
`endif
        e_out_w[c] = 4'(m_w[c]); e_out_s[c] = 4'(m_s[c]);
        e_ov_w[c] = fo_w[c]; e_un_w[c] = fu_w[c]; e_ov_s[c] = fo_s[c]; e_un_s[c] = fu_s[c];
        e_max_w[c] = (m_w[c] == MAXV); e_min_w[c] = (m_w[c] == 0);
      end
      tick();
      if (if_w.out !== e_out_w || if_w.overflow !== e_ov_w || if_w.underflow !== e_un_w) begin
        n_fail++; $display("FAIL soak_wrap cyc %0d: got out=%h ov=%b un=%b expected out=%h ov=%b un=%b",
                           cyc, if_w.out, if_w.overflow, if_w.underflow, e_out_w, e_ov_w, e_un_w);
      end
      n_checks++;
      if (if_s.out !== e_out_s || if_s.overflow !== e_ov_s || if_s.underflow !== e_un_s) begin
        n_fail++; $display("FAIL soak_sat cyc %0d: got out=%h ov=%b un=%b expected out=%h ov=%b un=%b",
                           cyc, if_s.out, if_s.overflow, if_s.underflow, e_out_s, e_ov_s, e_un_s);
      end
      n_checks++;
      if (if_w.at_max !== e_max_w || if_w.at_min !== e_min_w) begin
        n_fail++; $display("FAIL soak_limits cyc %0d: got max=%b min=%b expected max=%b min=%b",
                           cyc, if_w.at_max, if_w.at_min, e_max_w, e_min_w);
      end
      n_checks++;
    end
    clear_inputs();
  endtask

  // sequence and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    test_reset();
    test_wrap();
    test_saturate();
    test_simultaneous();
    test_flags();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
